// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one asynchronous-read / synchronous-write data RAM between a CPU data
// port and a burst-read (DMA-style) client.
//
// While no burst is active the CPU owns the RAM. An accepted burst request
// moves the block into BURST, where a word is read in any cycle the CPU does
// not request the RAM. If the CPU keeps requesting, the burst word is forced
// through after MAX_WAIT denied cycles, and the CPU is stalled for that cycle.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   c_req/c_we/c_addr/    CPU access request, write enable, word address,
//   c_wdata               write data
//   c_rdata, c_stall      CPU read data (RAM passthrough), access not granted
//   d_req/d_addr/d_len    burst request (level), base word address, length-1
//   d_ack                 one-cycle pulse when a burst is accepted
//   d_rdata/d_valid       registered burst word and its one-cycle valid pulse
//   d_done                pulse with the last d_valid of a burst
//   mem_a/mem_d/mem_we    RAM address, write data, write enable
//   mem_spo               RAM asynchronous read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW       = 15,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [3:0]    d_len,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          d_done,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_we,
  input  logic [DW-1:0] mem_spo
);

  localparam int            WW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]    state_q,   state_d;
  logic [AW-1:0] base_q,    base_d;
  logic [3:0]    len_q,     len_d;
  logic [3:0]    idx_q,     idx_d;
  logic [WW-1:0] wait_q,    wait_d;
  logic          d_ack_q,   d_ack_d;
  logic          d_valid_q, d_valid_d;
  logic          d_done_q,  d_done_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic          in_burst;
  logic          dma_gnt;
  logic          cpu_gnt;
  logic [AW-1:0] burst_a;

  // Grant decision. In IDLE the CPU is always granted; in BURST the burst wins
  // whenever the CPU is quiet or has already been let through MAX_WAIT times.
  always_comb begin
    in_burst = (state_q == S_BURST);
    dma_gnt  = in_burst & (~c_req | (wait_q == WAIT_MAX));
    cpu_gnt  = in_burst ? (c_req & ~dma_gnt) : c_req;
    // Truncation to AW bits gives the required address wrap-around.
    burst_a  = base_q + AW'(idx_q);
    mem_a    = dma_gnt ? burst_a : c_addr;
    // rst_n gating keeps the RAM and CPU quiet while reset is held.
    mem_we   = rst_n & c_req & c_we & cpu_gnt;
    c_stall  = rst_n & c_req & ~cpu_gnt;
  end

  assign mem_d   = c_wdata;
  assign c_rdata = mem_spo;
  assign d_ack   = d_ack_q;
  assign d_valid = d_valid_q;
  assign d_done  = d_done_q;
  assign d_rdata = d_rdata_q;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    d_ack_d   = 1'b0;
    d_valid_d = 1'b0;
    d_done_d  = 1'b0;
    d_rdata_d = d_rdata_q;
    if (state_q == S_IDLE) begin
      if (d_req) begin
        base_d  = d_addr;
        len_d   = d_len;
        idx_d   = 4'd0;
        wait_d  = '0;
        d_ack_d = 1'b1;
        state_d = S_BURST;
      end
    end else begin
      // d_req is deliberately not looked at here.
      if (dma_gnt) begin
        d_rdata_d = mem_spo;
        d_valid_d = 1'b1;
        idx_d     = idx_q + 4'd1;
        wait_d    = '0;
        if (idx_q == len_q) begin
          d_done_d = 1'b1;
          state_d  = S_IDLE;
        end
      end else if (wait_q != WAIT_MAX) begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      wait_q    <= '0;
      d_ack_q   <= 1'b0;
      d_valid_q <= 1'b0;
      d_done_q  <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      d_ack_q   <= d_ack_d;
      d_valid_q <= d_valid_d;
      d_done_q  <= d_done_d;
      d_rdata_q <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_req = 1'b0;
  logic          c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic          d_req = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [3:0]    d_len = '0;
  logic [DW-1:0] c_rdata, d_rdata, mem_d, mem_spo;
  logic          c_stall, d_ack, d_valid, d_done, mem_we;
  logic [AW-1:0] mem_a;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_addr(d_addr), .d_len(d_len),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_valid(d_valid), .d_done(d_done),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo)
  );

  function automatic logic [DW-1:0] seed_word(int a);
    return DW'(a) * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  // RAM: asynchronous read, synchronous write, preloaded on the first edge.
  logic [DW-1:0] ram [DEPTH];
  logic          ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= seed_word(i);
    end else if (mem_we) begin
      ram[mem_a] <= mem_d;
    end
  end
  assign mem_spo = ram[mem_a];

  // Reference model: a shadow memory plus a queue of burst addresses still owed.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [AW-1:0] m_addrs [$];
  bit            m_busy;
  int            m_wait;
  bit            e_ack, e_valid, e_done, e_dma, e_stall, e_we;
  logic [DW-1:0] e_rdata;
  logic [AW-1:0] e_a;

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_addrs.delete();
    e_ack = 0; e_valid = 0; e_done = 0; e_rdata = '0;
  endtask

  task automatic model_eval();
    e_dma   = m_busy && (!c_req || m_wait == MAX_WAIT);
    e_stall = c_req && e_dma;
    e_we    = c_req && c_we && !e_dma;
    e_a     = e_dma ? m_addrs[0] : c_addr;
  endtask

  task automatic model_commit();
    e_ack = 0; e_valid = 0; e_done = 0;
    if (e_we) ref_mem[c_addr] = c_wdata;
    if (!m_busy) begin
      if (d_req) begin
        for (int i = 0; i <= int'(d_len); i++) m_addrs.push_back(AW'(int'(d_addr) + i));
        m_busy = 1; m_wait = 0; e_ack = 1;
      end
    end else if (e_dma) begin
      e_rdata = ref_mem[m_addrs.pop_front()];
      e_valid = 1; m_wait = 0;
      if (m_addrs.size() == 0) begin e_done = 1; m_busy = 0; end
    end else if (m_wait < MAX_WAIT) begin
      m_wait++;
    end
  endtask

  task automatic half();
    @(negedge clk);
    model_eval();
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    c_req = 1; c_we = 1; c_addr = AW'(7); c_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
    checks++; if (c_stall !== 1'b0) begin errors++; $display("FAIL reset_c_stall: got %0b want 0", c_stall); end
    checks++; if ({d_ack, d_valid, d_done} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {d_ack, d_valid, d_done}); end
    checks++; if (d_rdata !== '0) begin errors++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
    @(posedge clk); #1;
    c_req = 0; c_we = 0;
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++; if ({d_ack, d_valid, d_done} !== 3'b000) begin errors++; $display("FAIL post_reset_pulses: got %b want 000", {d_ack, d_valid, d_done}); end
  endtask

  task automatic test_cpu_wr_rd();
    c_req = 1; c_we = 1; c_addr = AW'(5); c_wdata = 32'hA5A5_A5A5;
    half();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL cpu_wr_mem_we: got %0b want 1", mem_we); end
    checks++; if (c_stall !== 1'b0) begin errors++; $display("FAIL cpu_wr_stall: got %0b want 0", c_stall); end
    clk_edge();
    c_we = 0; c_wdata = '0;
    half();
    checks++; if (c_rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL cpu_rd_data: got %h want a5a5a5a5", c_rdata); end
    clk_edge();
    c_req = 0;
  endtask

  task automatic test_burst();
    d_req = 1; d_addr = AW'(16); d_len = 4'd3; c_req = 0;
    half(); clk_edge();
    checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL burst_ack: got %0b want 1", d_ack); end
    d_req = 0;
    for (int k = 0; k < 4; k++) begin
      half();
      checks++; if (mem_a !== AW'(16 + k)) begin errors++; $display("FAIL burst_mem_a[%0d]: got %h want %h", k, mem_a, AW'(16 + k)); end
      clk_edge();
      checks++; if (d_valid !== 1'b1 || d_ack !== 1'b0) begin errors++; $display("FAIL burst_valid[%0d]: got v=%0b a=%0b want v=1 a=0", k, d_valid, d_ack); end
      checks++; if (d_rdata !== ref_mem[16 + k]) begin errors++; $display("FAIL burst_data[%0d]: got %h want %h", k, d_rdata, ref_mem[16 + k]); end
      checks++; if (d_done !== (k == 3)) begin errors++; $display("FAIL burst_done[%0d]: got %0b want %0b", k, d_done, (k == 3)); end
    end
    half(); clk_edge();
    checks++; if ({d_valid, d_done} !== 2'b00) begin errors++; $display("FAIL burst_after: got %b want 00", {d_valid, d_done}); end
  endtask

  task automatic test_starvation();
    c_req = 1; c_we = 0; c_addr = AW'(256);
    d_req = 1; d_addr = AW'(64); d_len = 4'd1;
    half(); clk_edge();
    checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL starve_ack: got %0b want 1", d_ack); end
    d_req = 0;
    for (int j = 0; j < 10; j++) begin
      half();
      checks++; if (c_stall !== (j % 5 == 4)) begin errors++; $display("FAIL starve_stall[%0d]: got %0b want %0b", j, c_stall, (j % 5 == 4)); end
      clk_edge();
      checks++; if (d_valid !== (j % 5 == 4) || d_done !== (j == 9)) begin errors++; $display("FAIL starve_valid[%0d]: got v=%0b d=%0b want v=%0b d=%0b", j, d_valid, d_done, (j % 5 == 4), (j == 9)); end
      if (j % 5 == 4) begin
        checks++; if (d_rdata !== ref_mem[64 + j / 5]) begin errors++; $display("FAIL starve_data[%0d]: got %h want %h", j, d_rdata, ref_mem[64 + j / 5]); end
      end
    end
    c_req = 0;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4] = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    d_req = 1; d_addr = 15'h7FFE; d_len = 4'd3; c_req = 0;
    half(); clk_edge();
    d_req = 0;
    for (int k = 0; k < 4; k++) begin
      half();
      checks++; if (mem_a !== exp_a[k]) begin errors++; $display("FAIL wrap_mem_a[%0d]: got %h want %h", k, mem_a, exp_a[k]); end
      clk_edge();
      checks++; if (d_rdata !== ref_mem[exp_a[k]] || d_valid !== 1'b1) begin errors++; $display("FAIL wrap_data[%0d]: got %h v=%0b want %h v=1", k, d_rdata, d_valid, ref_mem[exp_a[k]]); end
    end
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_addr = AW'(512); d_len = 4'd7; c_req = 0;
    half(); clk_edge();
    d_req = 0;
    half(); clk_edge();
    half(); clk_edge();
    checks++; if (d_valid !== 1'b1 || d_rdata !== ref_mem[513]) begin errors++; $display("FAIL rstmid_word2: got v=%0b %h want v=1 %h", d_valid, d_rdata, ref_mem[513]); end
    @(negedge clk); #2;
    rst_n = 0; c_req = 1; c_we = 1; c_addr = AW'(9);
    #1;
    checks++; if ({d_valid, d_done, d_ack} !== 3'b000 || d_rdata !== '0) begin errors++; $display("FAIL rstmid_clear: got v/d/a=%b %h want 000 0", {d_valid, d_done, d_ack}, d_rdata); end
    checks++; if (mem_we !== 1'b0 || c_stall !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got we=%0b st=%0b want 0 0", mem_we, c_stall); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL rstmid_nodone[%0d]: got %0b want 0", i, d_done); end
    end
    c_req = 0; c_we = 0;
    #2 rst_n = 1;
    model_reset();
    @(posedge clk); #1;
    d_req = 1; d_addr = AW'(768); d_len = 4'd0;
    half(); clk_edge();
    checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL rstmid_reack: got %0b want 1", d_ack); end
    d_req = 0;
    half(); clk_edge();
    checks++; if (d_valid !== 1'b1 || d_done !== 1'b1 || d_rdata !== ref_mem[768]) begin errors++; $display("FAIL rstmid_newburst: got v=%0b d=%0b %h want 1 1 %h", d_valid, d_done, d_rdata, ref_mem[768]); end
  endtask

  task automatic test_back_to_back();
    d_req = 1; d_addr = AW'(48); d_len = 4'd1; c_req = 0;
    half(); clk_edge();
    checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1: got %0b want 1", d_ack); end
    d_addr = AW'(32); d_len = 4'd2;
    for (int i = 0; i < 2; i++) begin
      half(); clk_edge();
      checks++; if (d_ack !== 1'b0 || d_valid !== 1'b1 || d_done !== (i == 1) || d_rdata !== ref_mem[48 + i]) begin
        errors++; $display("FAIL b2b_first[%0d]: got a=%0b v=%0b d=%0b %h want 0 1 %0b %h", i, d_ack, d_valid, d_done, d_rdata, (i == 1), ref_mem[48 + i]); end
    end
    half(); clk_edge();
    checks++; if (d_ack !== 1'b1 || d_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack2: got a=%0b v=%0b want 1 0", d_ack, d_valid); end
    d_req = 0;
    for (int i = 0; i < 3; i++) begin
      half(); clk_edge();
      checks++; if (d_valid !== 1'b1 || d_done !== (i == 2) || d_rdata !== ref_mem[32 + i]) begin
        errors++; $display("FAIL b2b_second[%0d]: got v=%0b d=%0b %h want 1 %0b %h", i, d_valid, d_done, d_rdata, (i == 2), ref_mem[32 + i]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      c_req   = ($urandom_range(0, 99) < 60);
      c_we    = 1'($urandom_range(0, 1));
      c_addr  = AW'($urandom_range(0, 63));
      c_wdata = $urandom();
      if (!d_req && $urandom_range(0, 9) < 3) begin
        d_req  = 1;
        d_addr = ($urandom_range(0, 3) == 0) ? AW'(32'h7FF8 + $urandom_range(0, 7)) : AW'($urandom_range(0, 63));
        d_len  = 4'($urandom_range(0, 15));
      end
      half();
      checks++; if (c_stall !== e_stall || mem_we !== e_we) begin errors++; $display("FAIL rnd_grant[%0d]: got st=%0b we=%0b want %0b %0b", n, c_stall, mem_we, e_stall, e_we); end
      checks++; if (mem_a !== e_a || c_rdata !== ref_mem[e_a] || mem_d !== c_wdata) begin errors++; $display("FAIL rnd_addr[%0d]: got a=%h rd=%h want a=%h rd=%h", n, mem_a, c_rdata, e_a, ref_mem[e_a]); end
      clk_edge();
      checks++; if ({d_ack, d_valid, d_done} !== {e_ack, e_valid, e_done}) begin errors++; $display("FAIL rnd_pulses[%0d]: got %b want %b", n, {d_ack, d_valid, d_done}, {e_ack, e_valid, e_done}); end
      checks++; if (d_rdata !== e_rdata) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", n, d_rdata, e_rdata); end
      if (e_ack && $urandom_range(0, 3) != 0) d_req = 0;
    end
    d_req = 0; c_req = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
    model_reset();
    @(posedge clk); #1;
    ram_init = 1'b1;
    test_reset();
    test_cpu_wr_rd();
    test_burst();
    test_starvation();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
